// File: rtl/riscv_pkg.sv
// Shared RV32I constants and types for the fetch stage.
package riscv_pkg;

  localparam logic [6:0]  OP_JAL           = 7'b110_1111;
  localparam logic [31:0] INSN_NOP         = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One prefetch entry: the PC the word was fetched from and the word itself.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Sign-extended J-type immediate (jal offset).
  function automatic logic [31:0] imm_j(input logic [31:0] insn);
    return {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO holding {pc, instr} entries between the memory response
// channel and the IF output register. Clear has priority over push/pop.
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  input  logic               clear,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count,
  output logic               empty
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_wr_next;
  logic [PTR_W-1:0] w_rd_next;

  assign w_wr_next = PTR_W'((int'(r_wr_ptr) + 1) % DEPTH);
  assign w_rd_next = PTR_W'((int'(r_rd_ptr) + 1) % DEPTH);

  // Storage write; only the pointers and count define which entries are live.
  // NOTE: the data array has no reset -- stale contents are never read because
  // the count gates every pop, and leaving it unreset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (push && !clear) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= w_wr_next;
      if (pop)  r_rd_ptr <= w_rd_next;
      r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);

endmodule

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage RV32I pipeline: sequential fetch with a credit-limited
// request channel, in-order variable-latency responses, a small prefetch FIFO
// and one instruction per cycle to ID. Flush from EX redirects and discards
// stale responses still in flight.
// Optional build macro RV_FETCH_JAL_PREDICT_EN: when a jal reaches the output
// register, IF redirects itself to the jal target the following cycle and
// flags that instruction with pred_taken_out.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
`ifdef RV_FETCH_JAL_PREDICT_EN
  output logic        pred_taken_out,
`endif
  output logic        valid_out
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_rsp_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_discard;
  logic [31:0]      r_pc_out;
  logic [31:0]      r_instr_out;
  logic             r_valid_out;

  logic             w_int_redirect;
  logic             w_redirect;
  logic [31:0]      w_redirect_pc;
  logic [CNT_W:0]   w_credit_used;
  logic             w_hs;
  logic             w_rsp_drop;
  logic             w_rsp_accept;
  logic             w_out_load;
  logic             w_pop;
  logic             w_bypass;
  logic             w_push;
  fetch_entry_t     w_rsp_entry;
  fetch_entry_t     w_load_entry;
  fetch_entry_t     w_fifo_head;
  logic [CNT_W-1:0] w_fifo_count;
  logic             w_fifo_empty;

`ifdef RV_FETCH_JAL_PREDICT_EN
  logic        r_jal_pending;
  logic        r_pred_taken;
  logic        w_load_is_jal;
  logic [31:0] w_jal_target;

  // The jal still sits in the output register during the redirect cycle.
  assign w_jal_target   = (r_pc_out + imm_j(r_instr_out)) & ~32'd3;
  assign w_int_redirect = r_jal_pending;
  assign w_redirect_pc  = flush ? (redirect_pc & ~32'd3) : w_jal_target;
  assign w_load_is_jal  = (w_load_entry.instr[6:0] == OP_JAL);
`else
  assign w_int_redirect = 1'b0;
  assign w_redirect_pc  = redirect_pc & ~32'd3;
`endif

  assign w_redirect = flush | w_int_redirect;

  // Credits: requests in flight plus words already buffered may not exceed
  // the FIFO depth, so a stalled ID can never cause a response to be lost.
  assign w_credit_used  = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign imem_req_valid = rst_n && !w_redirect
                       && (w_credit_used < (CNT_W + 1)'(FIFO_DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_hs           = imem_req_valid && imem_req_ready;

  // Responses for requests issued before a redirect are dropped by count.
  assign w_rsp_drop   = imem_rsp_valid && (r_discard != '0);
  assign w_rsp_accept = imem_rsp_valid && (r_discard == '0) && !w_redirect;
  assign w_rsp_entry  = {r_rsp_pc, imem_rsp_data};

  // The output register takes a new value only when ID accepts and no
  // redirect is in progress; the FIFO head is older than a bypassed response.
  assign w_out_load = !flush && !stall && !w_int_redirect;
  assign w_pop      = w_out_load && !w_fifo_empty;
  assign w_bypass   = w_out_load && w_fifo_empty && w_rsp_accept;
  assign w_push     = w_rsp_accept && !w_bypass;

  // Select what the output register loads: FIFO head or the live response.
  // NOTE: assigning a default before any condition keeps this purely
  // combinational; a path that leaves it unassigned would infer a latch.
  always_comb begin
    w_load_entry = w_rsp_entry;
    if (w_pop) w_load_entry = w_fifo_head;
  end

  fetch_buffer #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_rsp_entry),
    .pop       (w_pop),
    .clear     (w_redirect),
    .head      (w_fifo_head),
    .count     (w_fifo_count),
    .empty     (w_fifo_empty)
  );

  // Fetch and response PCs: advance per handshake / accepted word, or jump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
    end else if (w_redirect) begin
      r_fetch_pc <= w_redirect_pc;
      r_rsp_pc   <= w_redirect_pc;
    end else begin
      if (w_hs)         r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_rsp_accept) r_rsp_pc   <= r_rsp_pc + 32'd4;
    end
  end

  // In-flight request count and number of stale responses still to drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= r_outstanding + CNT_W'(w_hs) - CNT_W'(imem_rsp_valid);
      if (w_redirect)      r_discard <= r_outstanding - CNT_W'(imem_rsp_valid);
      else if (w_rsp_drop) r_discard <= r_discard - CNT_W'(1);
    end
  end

  // Output register toward ID: flush clears, stall holds, else load or bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_out    <= '0;
      r_instr_out <= INSN_NOP;
      r_valid_out <= 1'b0;
    end else if (flush) begin
      r_instr_out <= INSN_NOP;
      r_valid_out <= 1'b0;
    end else if (!stall) begin
      if (w_pop || w_bypass) begin
        r_pc_out    <= w_load_entry.pc;
        r_instr_out <= w_load_entry.instr;
        r_valid_out <= 1'b1;
      end else begin
        r_instr_out <= INSN_NOP;
        r_valid_out <= 1'b0;
      end
    end
  end

`ifdef RV_FETCH_JAL_PREDICT_EN
  // Mark a loaded jal as predicted-taken and arm the next-cycle redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_jal_pending <= 1'b0;
      r_pred_taken  <= 1'b0;
    end else begin
      r_jal_pending <= (w_pop || w_bypass) && w_load_is_jal;
      if (flush)       r_pred_taken <= 1'b0;
      else if (!stall) r_pred_taken <= (w_pop || w_bypass) && w_load_is_jal;
    end
  end

  assign pred_taken_out = r_pred_taken;
`endif

  assign pc_out          = r_pc_out;
  assign instruction_out = r_instr_out;
  assign valid_out       = r_valid_out;

endmodule
